pipelined_multiplier: RTL

- Parametrised, 3-stage pipelined multiplier for the muldiv unit; successor to the fixed 16-bit combinational multiplier.
- Splits each operand into halves, forms four half-width partial products, then sums them.
- Supports all four RISC-V M-extension multiply flavours: MUL, MULH, MULHSU, MULHU.
- Valid/ready handshake on both sides; a tag travels with each operation for writeback.

---
 rtl/pipelined_multiplier_pkg.sv | 21 ++
 rtl/umul_half.sv | 12 +
 rtl/pipelined_multiplier.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipelined_multiplier_pkg.sv
// Shared muldiv definitions: multiply op encodings and the operand sign decode.
package pipelined_multiplier_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
  } sign_ctl_t;

  function automatic sign_ctl_t sign_ctl(input logic [1:0] op);
    sign_ctl_t s;
    s.a_signed = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    s.b_signed = (op == MUL_OP_MULH);
    return s;
  endfunction

endpackage

// File: rtl/umul_half.sv
// Combinational W x W -> 2W unsigned multiplier; replaceable by a Wallace tree or DSP macro.
module umul_half #(
  parameter int W = 16
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  assign p_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

endmodule

// File: rtl/pipelined_multiplier.sv
// 3-stage multiplier: S1 sign/magnitude prep, S2 four half-width partial products,
// S3 recombine, re-sign and pick the low or high half. The whole pipe stalls together.
module pipelined_multiplier
  import pipelined_multiplier_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int H = WIDTH / 2;

  logic             adv;
  logic [3:1]       vld_pipe_q;

  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s1_neg_q;
  logic [1:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic [WIDTH-1:0] s2_ll_q, s2_lh_q, s2_hl_q, s2_hh_q;
  logic             s2_neg_q;
  logic [1:0]       s2_op_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic [WIDTH-1:0] result_q;
  logic [TAG_W-1:0] tag_q;

  assign adv      = !vld_pipe_q[3] || ready_i;
  assign ready_o  = adv;
  assign valid_o  = vld_pipe_q[3];
  assign result_o = result_q;
  assign tag_o    = tag_q;

  // S1: magnitudes are WIDTH-bit unsigned, so the most negative input still fits
  sign_ctl_t        sc;
  logic [WIDTH-1:0] a_abs_d, b_abs_d;
  logic             neg_d;

  always_comb begin
    sc      = sign_ctl(op_i);
    a_abs_d = (sc.a_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    b_abs_d = (sc.b_signed && b_i[WIDTH-1]) ? -b_i : b_i;
    neg_d   = (sc.a_signed & a_i[WIDTH-1]) ^ (sc.b_signed & b_i[WIDTH-1]);
  end

  // S2
  logic [WIDTH-1:0] ll_d, lh_d, hl_d, hh_d;

  umul_half #(.W(H)) u_ll (.a_i(s1_a_q[H-1:0]),     .b_i(s1_b_q[H-1:0]),     .p_o(ll_d));
  umul_half #(.W(H)) u_lh (.a_i(s1_a_q[H-1:0]),     .b_i(s1_b_q[WIDTH-1:H]), .p_o(lh_d));
  umul_half #(.W(H)) u_hl (.a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[H-1:0]),     .p_o(hl_d));
  umul_half #(.W(H)) u_hh (.a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[WIDTH-1:H]), .p_o(hh_d));

  // S3: HH and LL occupy disjoint halves, so they concatenate; the middle sum keeps its carry
  logic [WIDTH:0]     mid_d;
  logic [2*WIDTH-1:0] prod_d, prod_s_d;
  logic [WIDTH-1:0]   result_d;

  always_comb begin
    mid_d    = {1'b0, s2_lh_q} + {1'b0, s2_hl_q};
    prod_d   = {s2_hh_q, s2_ll_q} + {{(H-1){1'b0}}, mid_d, {H{1'b0}}};
    prod_s_d = s2_neg_q ? -prod_d : prod_d;
    result_d = (s2_op_q == MUL_OP_MUL) ? prod_s_d[WIDTH-1:0] : prod_s_d[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_pipe_q <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_neg_q   <= 1'b0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s2_ll_q    <= '0;
      s2_lh_q    <= '0;
      s2_hl_q    <= '0;
      s2_hh_q    <= '0;
      s2_neg_q   <= 1'b0;
      s2_op_q    <= '0;
      s2_tag_q   <= '0;
      result_q   <= '0;
      tag_q      <= '0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[2:1], valid_i};
      s1_a_q     <= a_abs_d;
      s1_b_q     <= b_abs_d;
      s1_neg_q   <= neg_d;
      s1_op_q    <= op_i;
      s1_tag_q   <= tag_i;
      s2_ll_q    <= ll_d;
      s2_lh_q    <= lh_d;
      s2_hl_q    <= hl_d;
      s2_hh_q    <= hh_d;
      s2_neg_q   <= s1_neg_q;
      s2_op_q    <= s1_op_q;
      s2_tag_q   <= s1_tag_q;
      result_q   <= result_d;
      tag_q      <= s2_tag_q;
    end
  end

endmodule
